// File: rtl/quant_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined MultiplyByQuantizedMultiplier unit between NREQ requesters.
// Optional return checker enabled by defining QMA_ERR_CHECK_EN; otherwise err is tied low.
module quant_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x,
  input  logic [NREQ*32-1:0]   req_mult,
  input  logic [NREQ*32-1:0]   req_shift,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*32-1:0]   rsp_result,
  output logic [31:0]          mq_x,
  output logic [31:0]          mq_multiplier,
  output logic [31:0]          mq_shift,
  output logic                 mq_input_valid,
  input  logic [31:0]          mq_result,
  input  logic                 mq_output_valid,
  output logic                 err
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]           rr_q, rr_d;
  logic [NREQ-1:0]          busy_q, busy_d;
  logic [NREQ-1:0]          full_q, full_d;
  logic [31:0]              mq_x_q, mq_x_d;
  logic [31:0]              mq_mult_q, mq_mult_d;
  logic [31:0]              mq_shift_q, mq_shift_d;
  logic                     mq_iv_q, mq_iv_d;
  logic [IDW-1:0]           mq_id_q, mq_id_d;
  logic [LAT:0]             tag_v_q, tag_v_d;
  logic [LAT:0][IDW-1:0]    tag_id_q, tag_id_d;
  logic [NREQ*32-1:0]       rsp_result_q, rsp_result_d;

  logic [NREQ-1:0]          eligible;
  logic                     grant_any;
  logic [IDW-1:0]           grant_id;
  int                       idx;
  logic                     ret_fire;
  logic [IDW-1:0]           ret_id;

  // Gating with reset keeps req_ready low while the block is held in reset.
  assign eligible = req_valid & ~busy_q & ~full_q & {NREQ{reset}};

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx[IDW-1:0];
      end
    end
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  // The tag tail lines up with mq_output_valid because tags enter on the same edge the MBQM samples its input.
  assign ret_fire = mq_output_valid & tag_v_q[LAT];
  assign ret_id   = tag_id_q[LAT];

  always_comb begin
    rr_d         = rr_q;
    busy_d       = busy_q;
    full_d       = full_q & ~rsp_ready;
    mq_x_d       = mq_x_q;
    mq_mult_d    = mq_mult_q;
    mq_shift_d   = mq_shift_q;
    mq_iv_d      = grant_any;
    mq_id_d      = mq_id_q;
    tag_v_d      = {tag_v_q[LAT-1:0], mq_iv_q};
    tag_id_d     = {tag_id_q[LAT-1:0], mq_id_q};
    rsp_result_d = rsp_result_q;

    if (grant_any) begin
      mq_x_d           = req_x[32*int'(grant_id) +: 32];
      mq_mult_d        = req_mult[32*int'(grant_id) +: 32];
      mq_shift_d       = req_shift[32*int'(grant_id) +: 32];
      mq_id_d          = grant_id;
      busy_d[grant_id] = 1'b1;
      if (int'(grant_id) == NREQ - 1) rr_d = '0;
      else                            rr_d = grant_id + 1'b1;
    end

    // A returning requester is busy, so it can never be the one granted this cycle.
    if (ret_fire) begin
      busy_d[ret_id]                        = 1'b0;
      full_d[ret_id]                        = 1'b1;
      rsp_result_d[32*int'(ret_id) +: 32]   = mq_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q         <= '0;
      busy_q       <= '0;
      full_q       <= '0;
      mq_x_q       <= '0;
      mq_mult_q    <= '0;
      mq_shift_q   <= '0;
      mq_iv_q      <= 1'b0;
      mq_id_q      <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      rr_q         <= rr_d;
      busy_q       <= busy_d;
      full_q       <= full_d;
      mq_x_q       <= mq_x_d;
      mq_mult_q    <= mq_mult_d;
      mq_shift_q   <= mq_shift_d;
      mq_iv_q      <= mq_iv_d;
      mq_id_q      <= mq_id_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign mq_x           = mq_x_q;
  assign mq_multiplier  = mq_mult_q;
  assign mq_shift       = mq_shift_q;
  assign mq_input_valid = mq_iv_q;
  assign rsp_valid      = full_q;
  assign rsp_result     = rsp_result_q;

`ifdef QMA_ERR_CHECK_EN
  logic err_q, err_d;

  // Any disagreement between the tag tail and the MBQM return strobe is sticky.
  assign err_d = err_q | (mq_output_valid ^ tag_v_q[LAT]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
